// File: rtl/cgra_context_sequencer.sv
// Context sequencer for the PE array: holds a per-PE context table loaded by the host
// and streams one registered configuration word per PE per cycle while a run is active.
module cgra_context_sequencer #(
  parameter int NUM_PE       = 16,
  parameter int ContextWidth = 24,
  parameter int DEPTH        = 16,
  parameter int STEP_W       = $clog2(DEPTH),
  parameter int PE_W         = $clog2(NUM_PE),
  parameter int ITER_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_wr_en,
  output logic                           cfg_wr_ready,
  input  logic [PE_W-1:0]                cfg_wr_pe,
  input  logic [STEP_W-1:0]              cfg_wr_step,
  input  logic [ContextWidth-1:0]        cfg_wr_data,
  input  logic                           start,
  input  logic [STEP_W:0]                step_count,
  input  logic [ITER_W-1:0]              iter_count,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [STEP_W-1:0]              cur_step,
  output logic [ITER_W-1:0]              cur_iter,
  output logic [NUM_PE*ContextWidth-1:0] configuration,
  output logic                           dbg_state
);

  localparam int CW = ContextWidth;
  localparam logic [PE_W:0]   LP_NUM_PE = (PE_W+1)'(NUM_PE);
  localparam logic [STEP_W:0] LP_DEPTH  = (STEP_W+1)'(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Handshake: a table write is taken at the clock edge where cfg_wr_en=1 and
  // cfg_wr_ready=1; with cfg_wr_ready=0 the write is dropped and err pulses.

  state_t                     r_state;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_err;
  logic                       r_wr_ready;
  logic [STEP_W-1:0]          r_step;
  logic [ITER_W-1:0]          r_iter;
  logic [STEP_W-1:0]          r_step_last;
  logic [ITER_W-1:0]          r_iter_last;
  logic [NUM_PE*CW-1:0]       r_config;
  logic [CW-1:0]              r_table [NUM_PE][DEPTH];

  logic                       w_wr_in_range;
  logic                       w_wr_ok;
  logic                       w_start_req;
  logic                       w_start_legal;
  logic                       w_step_wrap;
  logic                       w_last_word;
  logic [STEP_W-1:0]          w_next_step;
  logic [STEP_W-1:0]          w_fetch_step;
  logic [NUM_PE*CW-1:0]       w_fetch_word;

  assign w_wr_in_range = ({1'b0, cfg_wr_pe} < LP_NUM_PE) && ({1'b0, cfg_wr_step} < LP_DEPTH);
  assign w_wr_ok       = (r_state == ST_IDLE) && cfg_wr_en && w_wr_in_range;

  // Abort takes priority over a start presented in the same cycle.
  assign w_start_req   = (r_state == ST_IDLE) && start && !abort;
  assign w_start_legal = (step_count != '0) && (step_count <= LP_DEPTH) && (iter_count != '0);

  assign w_step_wrap   = (r_step == r_step_last);
  assign w_last_word   = w_step_wrap && (r_iter == r_iter_last);
  assign w_next_step   = w_step_wrap ? '0 : r_step + STEP_W'(1);
  assign w_fetch_step  = (r_state == ST_RUN) ? w_next_step : '0;

  always_comb begin
    w_fetch_word = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      w_fetch_word[p*CW +: CW] = r_table[p][w_fetch_step];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PE; p++) begin
        for (int s = 0; s < DEPTH; s++) begin
          r_table[p][s] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < NUM_PE; p++) begin
        for (int s = 0; s < DEPTH; s++) begin
          if (w_wr_ok && (cfg_wr_pe == PE_W'(p)) && (cfg_wr_step == STEP_W'(s))) begin
            r_table[p][s] <= cfg_wr_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_wr_ready  <= 1'b1;
      r_step      <= '0;
      r_iter      <= '0;
      r_step_last <= '0;
      r_iter_last <= '0;
      r_config    <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cfg_wr_en && !w_wr_in_range) begin
            r_err <= 1'b1;
          end
          if (w_start_req) begin
            if (w_start_legal) begin
              r_state     <= ST_RUN;
              r_busy      <= 1'b1;
              r_wr_ready  <= 1'b0;
              r_step      <= '0;
              r_iter      <= '0;
              r_step_last <= STEP_W'(step_count - (STEP_W+1)'(1));
              r_iter_last <= iter_count - ITER_W'(1);
              r_config    <= w_fetch_word;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (cfg_wr_en) begin
            r_err <= 1'b1;
          end
          // The all-zero word is a NOP context, so idle cycles drive zero.
          if (abort || w_last_word) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
            r_done     <= !abort;
            r_step     <= '0;
            r_iter     <= '0;
            r_config   <= '0;
          end else begin
            r_step   <= w_next_step;
            r_config <= w_fetch_word;
            if (w_step_wrap) begin
              r_iter <= r_iter + ITER_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_wr_ready  = r_wr_ready;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign cur_step      = r_step;
  assign cur_iter      = r_iter;
  assign configuration = r_config;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_cgra_context_sequencer.sv
// Bench for cgra_context_sequencer: vector table for single-cycle idle operations,
// hand sequences for run corners, and randomized runs against a table/queue model.
module tb_cgra_context_sequencer;

  localparam int NUM_PE = 16;
  localparam int CW     = 24;
  localparam int DEPTH  = 16;
  localparam int STEP_W = 4;
  localparam int PE_W   = 5;
  localparam int ITER_W = 16;
  localparam int W      = NUM_PE*CW;
  localparam int EW     = ITER_W + STEP_W + W;

  logic                 clk;
  logic                 rst;
  logic                 cfg_wr_en;
  logic                 cfg_wr_ready;
  logic [PE_W-1:0]      cfg_wr_pe;
  logic [STEP_W-1:0]    cfg_wr_step;
  logic [CW-1:0]        cfg_wr_data;
  logic                 start;
  logic [STEP_W:0]      step_count;
  logic [ITER_W-1:0]    iter_count;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [STEP_W-1:0]    cur_step;
  logic [ITER_W-1:0]    cur_iter;
  logic [W-1:0]         configuration;
  logic                 dbg_state;

  cgra_context_sequencer #(
    .NUM_PE(NUM_PE), .ContextWidth(CW), .DEPTH(DEPTH),
    .STEP_W(STEP_W), .PE_W(PE_W), .ITER_W(ITER_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_ready(cfg_wr_ready),
    .cfg_wr_pe(cfg_wr_pe), .cfg_wr_step(cfg_wr_step), .cfg_wr_data(cfg_wr_data),
    .start(start), .step_count(step_count), .iter_count(iter_count), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .cur_step(cur_step), .cur_iter(cur_iter),
    .configuration(configuration), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [CW-1:0]  m_table [NUM_PE][DEPTH];
  logic [EW-1:0]  exp_q[$];
  logic [W-1:0]   got_q[$];

  typedef struct {
    logic              wr_en;
    logic [PE_W-1:0]   pe;
    logic [STEP_W-1:0] step;
    logic [CW-1:0]     data;
    logic              st;
    logic [STEP_W:0]   sc;
    logic [ITER_W-1:0] ic;
    logic              exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model;
    for (int p = 0; p < NUM_PE; p++)
      for (int s = 0; s < DEPTH; s++)
        m_table[p][s] = '0;
  endtask

  // driver: one write request in IDLE, checked for err one cycle later
  task automatic idle_write(input int pe, input int step, input logic [CW-1:0] data);
    cfg_wr_en   = 1'b1;
    cfg_wr_pe   = PE_W'(pe);
    cfg_wr_step = STEP_W'(step);
    cfg_wr_data = data;
    tick;
    cfg_wr_en = 1'b0;
    chk1("idle_wr_err", err, pe >= NUM_PE);
    if (pe < NUM_PE) m_table[pe][step] = data;
  endtask

  // driver: start pulse; model builds the expected word stream
  task automatic launch(input int s, input int it);
    logic [W-1:0] w;
    step_count = (STEP_W+1)'(s);
    iter_count = ITER_W'(it);
    start      = 1'b1;
    tick;
    start = 1'b0;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < it; i++) begin
      for (int k = 0; k < s; k++) begin
        for (int p = 0; p < NUM_PE; p++) w[p*CW +: CW] = m_table[p][k];
        exp_q.push_back({ITER_W'(i), STEP_W'(k), w});
      end
    end
  endtask

  // scoreboard: consume exp_q one cycle at a time; optional abort / dropped write
  task automatic follow(input int abort_at, input int wr_at);
    logic [EW-1:0] e;
    int n;
    bit aborted;
    n = exp_q.size();
    aborted = 1'b0;
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      got_q.push_back(configuration);
      chk1("run_busy", busy, 1'b1);
      chkv("run_cfg", configuration, e[W-1:0]);
      chkv("run_step", W'(cur_step), W'(e[W +: STEP_W]));
      chkv("run_iter", W'(cur_iter), W'(e[W+STEP_W +: ITER_W]));
      chk1("run_err", err, (wr_at >= 0) && (k-1 == wr_at));
      chk1("run_done", done, 1'b0);
      chk1("run_ready", cfg_wr_ready, 1'b0);
      cfg_wr_en   = (k == wr_at);
      cfg_wr_pe   = '0;
      cfg_wr_step = '0;
      cfg_wr_data = '1;
      start       = 1'($urandom_range(0, 1));
      step_count  = (STEP_W+1)'($urandom_range(0, 31));
      iter_count  = ITER_W'($urandom);
      if (k == abort_at) begin
        abort = 1'b1;
        start = 1'b1;
        tick;
        abort     = 1'b0;
        start     = 1'b0;
        cfg_wr_en = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chkv("abort_cfg", configuration, '0);
        chk1("abort_done", done, 1'b0);
        chk1("abort_err", err, k == wr_at);
        tick;
        chk1("post_abort_done", done, 1'b0);
        chk1("post_abort_busy", busy, 1'b0);
        aborted = 1'b1;
        break;
      end
      tick;
      cfg_wr_en = 1'b0;
    end
    if (!aborted) begin
      chk1("done_pulse", done, 1'b1);
      chk1("done_busy", busy, 1'b0);
      chkv("done_cfg", configuration, '0);
      chk1("done_err", err, (wr_at >= 0) && (n-1 == wr_at));
      chk1("done_ready", cfg_wr_ready, 1'b1);
      start = 1'b0;
    end
    exp_q.delete();
  endtask

  initial begin
    logic [CW-1:0] pe0_exp[6];
    int s, it, ab, wa, nw;

    vecs[0]  = '{1'b1, 5'd0,  4'd0,  24'h000011, 1'b0, 5'd0,  16'd0, 1'b0};
    vecs[1]  = '{1'b1, 5'd0,  4'd1,  24'h000022, 1'b0, 5'd0,  16'd0, 1'b0};
    vecs[2]  = '{1'b1, 5'd0,  4'd2,  24'h000033, 1'b0, 5'd0,  16'd0, 1'b0};
    vecs[3]  = '{1'b1, 5'd15, 4'd1,  24'hABCDEF, 1'b0, 5'd0,  16'd0, 1'b0};
    vecs[4]  = '{1'b1, 5'd16, 4'd0,  24'hDEAD01, 1'b0, 5'd0,  16'd0, 1'b1};
    vecs[5]  = '{1'b0, 5'd0,  4'd0,  24'h000000, 1'b1, 5'd0,  16'd1, 1'b1};
    vecs[6]  = '{1'b0, 5'd0,  4'd0,  24'h000000, 1'b1, 5'd3,  16'd0, 1'b1};
    vecs[7]  = '{1'b0, 5'd0,  4'd0,  24'h000000, 1'b1, 5'd17, 16'd2, 1'b1};
    vecs[8]  = '{1'b1, 5'd31, 4'd2,  24'hBAD000, 1'b0, 5'd0,  16'd0, 1'b1};
    vecs[9]  = '{1'b1, 5'd7,  4'd15, 24'h123456, 1'b0, 5'd0,  16'd0, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  4'd0,  24'h000000, 1'b1, 5'd16, 16'd0, 1'b1};
    pe0_exp = '{24'h000011, 24'h000022, 24'h000033, 24'h000011, 24'h000022, 24'h000033};

    rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_pe = '0; cfg_wr_step = '0; cfg_wr_data = '0;
    start = 1'b0; step_count = '0; iter_count = '0; abort = 1'b0;
    clear_model();

    // reset
    tick;
    tick;
    chkv("rst_cfg", configuration, '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", cfg_wr_ready, 1'b1);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    rst = 1'b0;
    tick;
    launch(16, 1);
    follow(-1, -1);

    // idle-state vector table: writes, illegal writes, illegal starts
    for (int v = 0; v < 11; v++) begin
      cfg_wr_en   = vecs[v].wr_en;
      cfg_wr_pe   = vecs[v].pe;
      cfg_wr_step = vecs[v].step;
      cfg_wr_data = vecs[v].data;
      start       = vecs[v].st;
      step_count  = vecs[v].sc;
      iter_count  = vecs[v].ic;
      tick;
      cfg_wr_en = 1'b0;
      start     = 1'b0;
      chk1("vec_err", err, vecs[v].exp_err);
      chk1("vec_busy", busy, 1'b0);
      chk1("vec_ready", cfg_wr_ready, 1'b1);
      if (vecs[v].wr_en && (int'(vecs[v].pe) < NUM_PE))
        m_table[vecs[v].pe][vecs[v].step] = vecs[v].data;
    end
    tick;
    chk1("vec_err_clear", err, 1'b0);

    // S=3, I=2 worked example
    launch(3, 2);
    follow(-1, -1);
    chkv("t2_len", W'(got_q.size()), W'(6));
    for (int k = 0; k < got_q.size() && k < 6; k++) begin
      chkv("t2_pe0", W'(got_q[k][CW-1:0]), W'(pe0_exp[k]));
      chkv("t2_pe15", W'(got_q[k][15*CW +: CW]), (k == 1 || k == 4) ? W'(24'hABCDEF) : W'(0));
    end
    tick;

    // single step, single iteration
    launch(1, 1);
    follow(-1, -1);
    tick;

    // abort at the 5th busy cycle, then a write during a run
    launch(4, 3);
    follow(4, -1);
    launch(2, 2);
    follow(-1, 1);
    tick;
    launch(1, 1);
    follow(-1, -1);
    chkv("wr_dropped_pe0", W'(got_q[0][CW-1:0]), W'(24'h000011));

    // back-to-back: restart in the done cycle
    launch(2, 1);
    follow(-1, -1);
    launch(3, 1);
    follow(-1, -1);
    tick;

    // reset mid-run clears outputs and table
    launch(4, 2);
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chkv("mid_rst_cfg", configuration, '0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    chk1("mid_rst_err", err, 1'b0);
    chk1("mid_rst_ready", cfg_wr_ready, 1'b1);
    chkv("mid_rst_step", W'(cur_step), '0);
    chkv("mid_rst_iter", W'(cur_iter), '0);
    clear_model();
    exp_q.delete();
    launch(4, 1);
    follow(-1, -1);
    tick;

    // randomized loads and runs against the model
    for (int r = 0; r < 25; r++) begin
      nw = $urandom_range(0, 4);
      for (int j = 0; j < nw; j++)
        idle_write($urandom_range(0, 19), $urandom_range(0, DEPTH-1), CW'($urandom));
      s  = $urandom_range(1, DEPTH);
      it = $urandom_range(1, 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, s*it-1) : -1;
      wa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, s*it-1) : -1;
      launch(s, it);
      follow(ab, wa);
      tick;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
